adc_spi_sampler: RTL and testbench
==================================

ADC_SPI_SAMPLER -- requirements
Module: adc_spi_sampler

Interface
REQ-001 Parameter CLK_DIV, default 25: sysclk cycles per SCK half-period (1 MHz SCK at 50 MHz sysclk); legal range 1..255.
REQ-002 Parameter SAMPLE_PERIOD, default 5000: sysclk cycles between conversion starts (10 kHz at 50 MHz); legal range 2..65535.
REQ-003 sysclk  in  1  single system clock; all logic rising-edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 enable  in  1  high = start conversions on sample ticks.
REQ-006 channel  in  1  MCP3002 channel select (0 = CH0, 1 = CH1).
REQ-007 adc_sdo  in  1  serial data from ADC (MISO).
REQ-008 adc_cs  out  1  ADC chip select, active-low.
REQ-009 adc_sck  out  1  SPI clock, idle low (mode 0,0).
REQ-010 adc_sdi  out  1  serial command to ADC (MOSI).
REQ-011 data_out  out  10  last converted sample, unsigned offset binary; feeds processor data_in.
REQ-012 data_valid  out  1  level; high while data_out holds a completed sample; feeds processor data_valid.
REQ-013 overrun  out  1  one-cycle pulse when a sample tick arrives while a frame is in progress.

Function
REQ-014 Sample timer SHALL count 0..SAMPLE_PERIOD-1 and wrap, free-running regardless of enable; tick = (count == SAMPLE_PERIOD-1); first tick SAMPLE_PERIOD cycles after rst release.
REQ-015 FSM states SHALL be IDLE, LOW, HIGH, DONE; transitions IDLE->LOW on tick & enable; LOW->HIGH after CLK_DIV cycles; HIGH->LOW after CLK_DIV cycles if bit index < 15, else HIGH->DONE; DONE->IDLE after one cycle.
REQ-016 On IDLE->LOW, adc_cs SHALL fall on the next sysclk edge, data_valid SHALL fall in the same cycle, bit index SHALL clear to 0, and channel SHALL be latched for the frame.
REQ-017 adc_sck SHALL be 0 in LOW, 1 in HIGH, 0 in IDLE/DONE; exactly 16 SCK pulses per frame; adc_cs low for exactly 32*CLK_DIV cycles.
REQ-018 adc_sdi SHALL present, for bit index 0..3, the values 1 (start), 1 (single-ended), latched channel, 1 (MSB first); 0 for index 4..15; updated on entry to LOW and stable through HIGH.
REQ-019 adc_sdo SHALL be sampled in the cycle SCK rises (LOW->HIGH); bits at index 5..14 shift into a 10-bit register MSB first (D9 at index 5); index 0..4 and 15 ignored.
REQ-020 In DONE, adc_cs SHALL return high, data_out SHALL load the shift register and data_valid SHALL rise, all on the same edge; data_out stable until the next completed frame.
REQ-021 data_valid SHALL stay high from DONE until the next frame's CS fall (rising edge per sample for downstream edge detection).
REQ-022 Tick while FSM not IDLE SHALL be ignored and SHALL pulse overrun for one cycle; no frame restart, no data corruption.
REQ-023 enable deasserted mid-frame SHALL NOT abort; frame completes, no further frames start while enable low.
REQ-024 channel changes mid-frame SHALL affect only the next frame.
REQ-025 Min non-overrun period: SAMPLE_PERIOD >= 32*CLK_DIV + 2.

Reset
REQ-026 While rst high: adc_cs=1, adc_sck=0, adc_sdi=0, data_out=0, data_valid=0, overrun=0, FSM=IDLE, timer=0, bit index=0.
REQ-027 rst asserted mid-frame SHALL force REQ-026 values immediately (asynchronously), discarding the partial sample; no frame starts until the first tick after release.

Verification (CLK_DIV=2, SAMPLE_PERIOD=100 unless stated)
REQ-028 Reset: assert rst anytime -> all outputs at REQ-026 values same cycle; first CS fall 101 cycles after release with enable=1.
REQ-029 ADC model returns 10'h2A5, channel=0 -> SDI bits 1,1,0,1,0...; CS low 64 cycles; data_out=10'h2A5, data_valid rises on CS rise.
REQ-030 Boundaries: channel=1 code 10'h3FF then channel=0 code 10'h000 -> SDI bit 2 = 1 then 0; data_out 10'h3FF then 10'h000; data_valid drops at each CS fall.
REQ-031 enable=0 for 500 cycles -> adc_cs stays 1, data_valid/data_out unchanged; enable dropped at SCK pulse 8 -> frame completes, no further CS fall.
REQ-032 rst pulse during SCK pulse 10 -> adc_cs=1, data_out=0, data_valid=0 immediately; next frame clean and returns correct code.
REQ-033 SAMPLE_PERIOD=50 -> overrun pulses once per colliding tick, every completed frame still returns the correct code.

Source files
------------

// File: rtl/adc_spi_sampler.sv
// -----------------------------------------------------------------------------
// adc_spi_sampler
//
// Periodically reads one conversion from an MCP3002 10-bit ADC over SPI
// (mode 0,0) and holds the result for a downstream processor.
//
// A free-running sample timer produces a tick every SAMPLE_PERIOD sysclk
// cycles. On a tick while enabled and idle, a 16-SCK frame is run:
// command bits start/single-ended/channel/MSB-first are shifted out on
// adc_sdi, and D9..D0 are captured from adc_sdo. When the frame ends,
// data_out is updated and data_valid rises. A tick that lands while a frame
// is still running is dropped and reported on overrun.
//
// Parameters
//   CLK_DIV        sysclk cycles per SCK half-period (1..255)
//   SAMPLE_PERIOD  sysclk cycles between conversion starts (2..65535);
//                  must be >= 32*CLK_DIV + 2 to avoid overruns
//
// Ports
//   sysclk      in   system clock, rising edge
//   rst         in   asynchronous active-high reset
//   enable      in   allow frames to start on sample ticks
//   channel     in   ADC channel select, latched at frame start
//   adc_sdo     in   serial data from ADC (MISO)
//   adc_cs      out  ADC chip select, active-low
//   adc_sck     out  SPI clock, idle low
//   adc_sdi     out  serial command to ADC (MOSI)
//   data_out    out  last completed 10-bit sample (unsigned offset binary)
//   data_valid  out  high while data_out holds a completed sample; drops
//                    at each CS fall so every sample gives a rising edge
//   overrun     out  one-cycle pulse when a tick arrives mid-frame
// -----------------------------------------------------------------------------
module adc_spi_sampler #(
   parameter int unsigned CLK_DIV       = 25,
   parameter int unsigned SAMPLE_PERIOD = 5000
) (
   input  logic       sysclk,
   input  logic       rst,
   input  logic       enable,
   input  logic       channel,
   input  logic       adc_sdo,
   output logic       adc_cs,
   output logic       adc_sck,
   output logic       adc_sdi,
   output logic [9:0] data_out,
   output logic       data_valid,
   output logic       overrun
);

   localparam int unsigned DATA_W  = 10;
   localparam logic [15:0] TICK_AT  = 16'(SAMPLE_PERIOD - 1);
   localparam logic [7:0]  DIV_LAST = 8'(CLK_DIV - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOW  = 2'd1,
      ST_HIGH = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   // MCP3002 command word, one bit per SCK pulse: start, single-ended,
   // channel, MSB-first; the remaining pulses just clock data out.
   function automatic logic cmd_bit(input logic [3:0] idx, input logic ch);
      logic b;
      case (idx)
         4'd0, 4'd1, 4'd3: b = 1'b1;
         4'd2:             b = ch;
         default:          b = 1'b0;
      endcase
      return b;
   endfunction

   state_t              state_q,   state_d;
   logic [15:0]         timer_q,   timer_d;
   logic [7:0]          div_q,     div_d;
   logic [3:0]          bit_q,     bit_d;
   logic                chan_q,    chan_d;
   logic                cs_q,      cs_d;
   logic                sck_q,     sck_d;
   logic                sdi_q,     sdi_d;
   logic [DATA_W-1:0]   shift_q,   shift_d;
   logic [DATA_W-1:0]   data_q,    data_d;
   logic                valid_q,   valid_d;
   logic                overrun_q, overrun_d;

   logic tick;
   logic div_last;
   logic data_bit;

   always_comb begin
      tick     = (timer_q == TICK_AT);
      div_last = (div_q == DIV_LAST);
      // Only pulses 5..14 carry D9..D0; earlier pulses are command/null.
      data_bit = (bit_q >= 4'd5) && (bit_q <= 4'd14);

      // Timer runs regardless of enable so the sample grid never drifts.
      timer_d   = tick ? 16'd0 : 16'(timer_q + 16'd1);
      overrun_d = tick && (state_q != ST_IDLE);

      state_d = state_q;
      div_d   = div_q;
      bit_d   = bit_q;
      chan_d  = chan_q;
      cs_d    = cs_q;
      sck_d   = sck_q;
      sdi_d   = sdi_q;
      shift_d = shift_q;
      data_d  = data_q;
      valid_d = valid_q;

      case (state_q)
         ST_IDLE: begin
            if (tick && enable) begin
               state_d = ST_LOW;
               div_d   = 8'd0;
               bit_d   = 4'd0;
               chan_d  = channel;
               cs_d    = 1'b0;
               sck_d   = 1'b0;
               sdi_d   = cmd_bit(4'd0, channel);
               valid_d = 1'b0;
            end
         end

         ST_LOW: begin
            if (div_last) begin
               state_d = ST_HIGH;
               div_d   = 8'd0;
               sck_d   = 1'b1;
               // ADC drives SDO on the falling edge, so it is settled here.
               if (data_bit) begin
                  shift_d = {shift_q[DATA_W-2:0], adc_sdo};
               end
            end else begin
               div_d = 8'(div_q + 8'd1);
            end
         end

         ST_HIGH: begin
            if (div_last) begin
               div_d = 8'd0;
               sck_d = 1'b0;
               if (bit_q != 4'd15) begin
                  state_d = ST_LOW;
                  bit_d   = 4'(bit_q + 4'd1);
                  sdi_d   = cmd_bit(4'(bit_q + 4'd1), chan_q);
               end else begin
                  state_d = ST_DONE;
                  cs_d    = 1'b1;
                  sdi_d   = 1'b0;
                  data_d  = shift_q;
                  valid_d = 1'b1;
               end
            end else begin
               div_d = 8'(div_q + 8'd1);
            end
         end

         ST_DONE: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge sysclk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         timer_q   <= 16'd0;
         div_q     <= 8'd0;
         bit_q     <= 4'd0;
         chan_q    <= 1'b0;
         cs_q      <= 1'b1;
         sck_q     <= 1'b0;
         sdi_q     <= 1'b0;
         shift_q   <= '0;
         data_q    <= '0;
         valid_q   <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         timer_q   <= timer_d;
         div_q     <= div_d;
         bit_q     <= bit_d;
         chan_q    <= chan_d;
         cs_q      <= cs_d;
         sck_q     <= sck_d;
         sdi_q     <= sdi_d;
         shift_q   <= shift_d;
         data_q    <= data_d;
         valid_q   <= valid_d;
         overrun_q <= overrun_d;
      end
   end

   assign adc_cs     = cs_q;
   assign adc_sck    = sck_q;
   assign adc_sdi    = sdi_q;
   assign data_out   = data_q;
   assign data_valid = valid_q;
   assign overrun    = overrun_q;

endmodule

// File: tb/tb_adc_spi_sampler.sv
// -----------------------------------------------------------------------------
// tb_adc_spi_sampler
//
// Main DUT: CLK_DIV=2, SAMPLE_PERIOD=100. Second DUT: CLK_DIV=2,
// SAMPLE_PERIOD=50 to exercise overrun. Each has a behavioural MCP3002
// model. The stimulus process queues the expected {code, channel} of every
// frame that should complete; a monitor pops one entry on each CS rise and
// checks the SDI command, SCK pulse count, CS low time and the result.
// -----------------------------------------------------------------------------
module tb_adc_spi_sampler;

   logic       sysclk = 1'b0;
   logic       rst, enable, channel, adc_sdo;
   logic       adc_cs, adc_sck, adc_sdi, data_valid, overrun;
   logic [9:0] data_out;

   logic       rst2, enable2, channel2, adc_sdo2;
   logic       adc_cs2, adc_sck2, adc_sdi2, data_valid2, overrun2;
   logic [9:0] data_out2;

   localparam logic [9:0] CODE2 = 10'h2DA;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [9:0] code;
      logic       ch;
   } exp_t;
   exp_t exp_q[$];

   logic [9:0] adc_code = 10'h000;

   always #5 sysclk = ~sysclk;

   adc_spi_sampler #(.CLK_DIV(2), .SAMPLE_PERIOD(100)) u_dut (
      .sysclk(sysclk), .rst(rst), .enable(enable), .channel(channel),
      .adc_sdo(adc_sdo), .adc_cs(adc_cs), .adc_sck(adc_sck),
      .adc_sdi(adc_sdi), .data_out(data_out), .data_valid(data_valid),
      .overrun(overrun)
   );

   adc_spi_sampler #(.CLK_DIV(2), .SAMPLE_PERIOD(50)) u_ovr (
      .sysclk(sysclk), .rst(rst2), .enable(enable2), .channel(channel2),
      .adc_sdo(adc_sdo2), .adc_cs(adc_cs2), .adc_sck(adc_sck2),
      .adc_sdi(adc_sdi2), .data_out(data_out2), .data_valid(data_valid2),
      .overrun(overrun2)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   // MCP3002 output for the SCK pulse with this index: D9..D0 on 5..14,
   // null bit 0 on 4; pulses the DUT must ignore are driven high.
   function automatic logic model_bit(input logic [9:0] code, input int idx);
      if (idx >= 5 && idx <= 14) return code[14-idx];
      if (idx <= 3 || idx == 15) return 1'b1;
      return 1'b0;
   endfunction

   // ---------------- main DUT: ADC model + scoreboard monitor ---------------
   logic       p_cs = 1'b1, p_sck = 1'b0;
   bit         in_frame = 1'b0;
   int         low_cnt = 0, sck_cnt = 0, ovr_main = 0;
   logic [15:0] sdi_cap = '0, exp_cmd;
   exp_t       e;

   always @(negedge sysclk) begin
      if (rst) begin
         in_frame = 1'b0;
         sck_cnt  = 0;
         adc_sdo  = 1'b0;
      end else begin
         if (p_cs && !adc_cs) begin
            in_frame = 1'b1;
            low_cnt  = 0;
            sck_cnt  = 0;
            sdi_cap  = '0;
            check("dv_drop_at_cs_fall", 32'(data_valid), 32'd0);
         end
         if (in_frame && !adc_cs) low_cnt++;
         if (in_frame && adc_sck && !p_sck) begin
            if (sck_cnt < 16) sdi_cap[sck_cnt] = adc_sdi;
            sck_cnt++;
         end
         if (in_frame && !p_cs && adc_cs) begin
            in_frame = 1'b0;
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_frame: got data_out %0h, required no frame", data_out);
            end else begin
               e = exp_q.pop_front();
               exp_cmd = 16'h000B | (16'(e.ch) << 2);
               check("sdi_command", 32'(sdi_cap), 32'(exp_cmd));
               check("sck_pulses", 32'(sck_cnt), 32'd16);
               check("cs_low_cycles", 32'(low_cnt), 32'd64);
               check("data_out", 32'(data_out), 32'(e.code));
               check("dv_rise_at_cs_rise", 32'(data_valid), 32'd1);
            end
         end
         if (overrun) ovr_main++;
         adc_sdo = (!adc_cs) ? model_bit(adc_code, sck_cnt) : 1'b0;
      end
      p_cs  = adc_cs;
      p_sck = adc_sck;
   end

   // ---------------- overrun DUT: ADC model + monitor ------------------------
   logic p_cs2 = 1'b1, p_sck2 = 1'b0, p_dv2 = 1'b0, p_ovr2 = 1'b0;
   int   sck_cnt2 = 0, ovr2_cnt = 0, ovr2_wide = 0, frames2 = 0;

   always @(negedge sysclk) begin
      if (rst2) begin
         sck_cnt2 = 0;
         adc_sdo2 = 1'b0;
      end else begin
         if (p_cs2 && !adc_cs2) sck_cnt2 = 0;
         if (!adc_cs2 && adc_sck2 && !p_sck2) sck_cnt2++;
         if (data_valid2 && !p_dv2) begin
            frames2++;
            check("ovr_data_out", 32'(data_out2), 32'(CODE2));
         end
         if (overrun2) ovr2_cnt++;
         if (overrun2 && p_ovr2) ovr2_wide++;
         adc_sdo2 = (!adc_cs2) ? model_bit(CODE2, sck_cnt2) : 1'b0;
      end
      p_cs2  = adc_cs2;
      p_sck2 = adc_sck2;
      p_dv2  = data_valid2;
      p_ovr2 = overrun2;
   end

   // ---------------- stimulus helpers ----------------------------------------
   task automatic wait_cs(input logic level, input int budget, input string name);
      int n = 0;
      while (adc_cs !== level && n < budget) begin
         @(negedge sysclk);
         n++;
      end
      check(name, 32'(adc_cs), 32'(level));
   endtask

   task automatic wait_sck_rises(input int count, input int budget);
      int   n = 0, seen = 0;
      logic prev = adc_sck;
      while (seen < count && n < budget) begin
         @(negedge sysclk);
         n++;
         if (adc_sck && !prev) seen++;
         prev = adc_sck;
      end
      check("sck_rises_seen", 32'(seen), 32'(count));
   endtask

   // Number of sysclk edges from reset release until CS is seen low.
   task automatic edges_to_cs_fall(output int n);
      n = 0;
      while (adc_cs && n < 300) begin
         @(negedge sysclk);
         n++;
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   int   n_edges;
   logic cs_seen_low;

   initial begin
      rst = 1'b1; enable = 1'b0; channel = 1'b0;
      rst2 = 1'b1; enable2 = 1'b0; channel2 = 1'b0;
      adc_sdo = 1'b0; adc_sdo2 = 1'b0;
      repeat (3) @(negedge sysclk);

      // Reset values
      check("rst_cs", 32'(adc_cs), 32'd1);
      check("rst_sck", 32'(adc_sck), 32'd0);
      check("rst_sdi", 32'(adc_sdi), 32'd0);
      check("rst_data_out", 32'(data_out), 32'd0);
      check("rst_data_valid", 32'(data_valid), 32'd0);
      check("rst_overrun", 32'(overrun), 32'd0);

      // First frame: code 2A5 on CH0; CS falls on edge 100 after release,
      // i.e. in the 101st cycle counting the release cycle.
      enable = 1'b1; channel = 1'b0; adc_code = 10'h2A5;
      exp_q.push_back('{10'h2A5, 1'b0});
      rst = 1'b0;
      edges_to_cs_fall(n_edges);
      check("first_cs_fall_edges", 32'(n_edges), 32'd100);
      wait_cs(1'b1, 200, "frame1_end");
      @(negedge sysclk);

      // Full-scale on CH1, then zero on CH0 with a mid-frame channel flip
      channel = 1'b1; adc_code = 10'h3FF;
      exp_q.push_back('{10'h3FF, 1'b1});
      wait_cs(1'b0, 200, "frame2_start");
      wait_cs(1'b1, 200, "frame2_end");
      @(negedge sysclk);

      channel = 1'b0; adc_code = 10'h000;
      exp_q.push_back('{10'h000, 1'b0});
      wait_cs(1'b0, 200, "frame3_start");
      channel = 1'b1;
      wait_cs(1'b1, 200, "frame3_end");
      @(negedge sysclk);

      // Disabled for 500 cycles: no frames, result held
      enable = 1'b0;
      cs_seen_low = 1'b0;
      repeat (500) begin
         @(negedge sysclk);
         if (!adc_cs) cs_seen_low = 1'b1;
      end
      check("disabled_cs_low", 32'(cs_seen_low), 32'd0);
      check("disabled_data_out", 32'(data_out), 32'h000);
      check("disabled_data_valid", 32'(data_valid), 32'd1);

      // Enable dropped at SCK pulse 8: frame still completes, then silence
      enable = 1'b1; channel = 1'b1; adc_code = 10'h1C3;
      exp_q.push_back('{10'h1C3, 1'b1});
      wait_cs(1'b0, 200, "frame4_start");
      wait_sck_rises(8, 100);
      enable = 1'b0;
      wait_cs(1'b1, 200, "frame4_end");
      cs_seen_low = 1'b0;
      repeat (300) begin
         @(negedge sysclk);
         if (!adc_cs) cs_seen_low = 1'b1;
      end
      check("after_drop_cs_low", 32'(cs_seen_low), 32'd0);
      check("after_drop_data_out", 32'(data_out), 32'h1C3);

      // Reset during SCK pulse 10 takes effect without a clock edge
      enable = 1'b1; channel = 1'b0; adc_code = 10'h16A;
      wait_cs(1'b0, 200, "frame5_start");
      wait_sck_rises(10, 100);
      #1 rst = 1'b1;
      #1;
      check("midrst_cs", 32'(adc_cs), 32'd1);
      check("midrst_sck", 32'(adc_sck), 32'd0);
      check("midrst_data_out", 32'(data_out), 32'd0);
      check("midrst_data_valid", 32'(data_valid), 32'd0);
      repeat (3) @(negedge sysclk);
      exp_q.push_back('{10'h16A, 1'b0});
      rst = 1'b0;
      edges_to_cs_fall(n_edges);
      check("post_rst_cs_fall_edges", 32'(n_edges), 32'd100);
      wait_cs(1'b1, 200, "frame6_end");
      @(negedge sysclk);
      enable = 1'b0;

      check("main_overrun_pulses", 32'(ovr_main), 32'd0);
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

      // SAMPLE_PERIOD=50: frames start on edges 50,150,250,350 and ticks on
      // edges 99,199,299,399 collide with a running frame.
      enable2 = 1'b1;
      rst2 = 1'b0;
      repeat (420) @(negedge sysclk);
      check("ovr_pulse_count", 32'(ovr2_cnt), 32'd4);
      check("ovr_pulse_width", 32'(ovr2_wide), 32'd0);
      check("ovr_frames_done", 32'(frames2), 32'd4);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
